// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with a ready/valid request handshake.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Compile-time option: define UART_TX_PARITY_EN to build the parity state and logic.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  input  logic [1:0]           i_Parity_Mode,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  // Reject illegal parameter values at elaboration
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state_q, state_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic                 stop_q, stop_n;
  logic [DATA_BITS-1:0] shreg_q, shreg_n;
  logic                 ser_q, ser_n;
  logic                 act_q, act_n;
  logic                 done_q, done_n;
  logic                 cnt_end;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_n;
  logic par_en_q, par_en_n;
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^i_Parity_Mode;
`endif

  assign cnt_end     = (cnt_q == CNT_LAST);
  assign o_Tx_Ready  = (state_q == IDLE);
  assign o_Tx_Active = act_q;
  assign o_Tx_Serial = ser_q;
  assign o_Tx_Done   = done_q;

  // State and datapath registers; async reset abandons any frame in flight
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      shreg_q  <= '0;
      ser_q    <= 1'b1;
      act_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      idx_q    <= idx_n;
      stop_q   <= stop_n;
      shreg_q  <= shreg_n;
      ser_q    <= ser_n;
      act_q    <= act_n;
      done_q   <= done_n;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_n;
      par_en_q <= par_en_n;
`endif
    end
  end

  // Next-state logic; the line level is registered with the state change so
  // each bit is on the pin for exactly CLKS_PER_BIT cycles
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    idx_n    = idx_q;
    stop_n   = stop_q;
    shreg_n  = shreg_q;
    ser_n    = ser_q;
    act_n    = act_q;
    done_n   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n    = par_q;
    par_en_n = par_en_q;
`endif
    case (state_q)
      IDLE: begin
        ser_n = 1'b1;
        if (i_Tx_DV) begin
          state_n  = START;
          cnt_n    = '0;
          shreg_n  = i_Tx_Byte;
          ser_n    = 1'b0;
          act_n    = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_en_n = (i_Parity_Mode == 2'b01) || (i_Parity_Mode == 2'b10);
          par_n    = (i_Parity_Mode == 2'b10) ? ~^i_Tx_Byte : ^i_Tx_Byte;
`endif
        end
      end
      START: begin
        if (cnt_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
          ser_n   = shreg_q[0];
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_end) begin
          cnt_n = '0;
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_n = PARITY;
              ser_n   = par_q;
            end else begin
              state_n = STOP;
              ser_n   = 1'b1;
              stop_n  = 1'b0;
            end
`else
            state_n = STOP;
            ser_n   = 1'b1;
            stop_n  = 1'b0;
`endif
          end else begin
            idx_n   = idx_q + 1'b1;
            shreg_n = shreg_q >> 1;
            ser_n   = shreg_q[1];
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (cnt_end) begin
          cnt_n   = '0;
          state_n = STOP;
          ser_n   = 1'b1;
          stop_n  = 1'b0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        ser_n = 1'b1;
        if (cnt_end) begin
          cnt_n = '0;
          if (stop_q == STOP_LAST) begin
            state_n = IDLE;
            act_n   = 1'b0;
            done_n  = 1'b1;
          end else begin
            stop_n = 1'b1;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        ser_n   = 1'b1;
        act_n   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed, table-driven checks of uart_tx_cfg in three configurations
// (8N1, 7-bit with parity option, 8-bit with two stop bits), CLKS_PER_BIT = 4.
module tb_uart_tx_cfg;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv = 1'b0;
  logic [7:0] tx_byte = '0;
  logic [1:0] mode = '0;
  int         sel = 0;

  logic rdy_a, act_a, ser_a, done_a;
  logic rdy_b, act_b, ser_b, done_b;
  logic rdy_c, act_c, ser_c, done_c;
  logic rdy, act, ser, done;

  int total = 0;
  int bad = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1)) u_a (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv && sel == 0), .i_Tx_Byte(tx_byte),
    .i_Parity_Mode(mode), .o_Tx_Ready(rdy_a), .o_Tx_Active(act_a),
    .o_Tx_Serial(ser_a), .o_Tx_Done(done_a));

  uart_tx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(7), .STOP_BITS(1)) u_b (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv && sel == 1), .i_Tx_Byte(tx_byte[6:0]),
    .i_Parity_Mode(mode), .o_Tx_Ready(rdy_b), .o_Tx_Active(act_b),
    .o_Tx_Serial(ser_b), .o_Tx_Done(done_b));

  uart_tx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(2)) u_c (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv && sel == 2), .i_Tx_Byte(tx_byte),
    .i_Parity_Mode(mode), .o_Tx_Ready(rdy_c), .o_Tx_Active(act_c),
    .o_Tx_Serial(ser_c), .o_Tx_Done(done_c));

  // Route the selected instance's outputs to the checker
  always_comb begin
    rdy = rdy_a; act = act_a; ser = ser_a; done = done_a;
    if (sel == 1) begin
      rdy = rdy_b; act = act_b; ser = ser_b; done = done_b;
    end else if (sel == 2) begin
      rdy = rdy_c; act = act_c; ser = ser_c; done = done_c;
    end
  end

  typedef struct {
    string       name;
    int          sel;
    logic [7:0]  data;
    logic [1:0]  mode;
    int          nbits;
    logic [15:0] bits;   // bit k = line level in bit period k (k=0 is start)
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Called just after the accept edge; walks every cycle up to the Done cycle
  task automatic check_frame(input string name, input int n, input logic [15:0] bits);
    for (int i = 0; i <= n * C; i++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (i < n * C) begin
        chk($sformatf("%s ser c%0d", name, i), {15'd0, ser}, {15'd0, bits[i / C]});
        chk($sformatf("%s done c%0d", name, i), {15'd0, done}, 16'd0);
        chk($sformatf("%s active c%0d", name, i), {15'd0, act}, 16'd1);
      end else begin
        chk($sformatf("%s ser end", name), {15'd0, ser}, 16'd1);
        chk($sformatf("%s done end", name), {15'd0, done}, 16'd1);
        chk($sformatf("%s active end", name), {15'd0, act}, 16'd0);
        chk($sformatf("%s ready end", name), {15'd0, rdy}, 16'd1);
      end
    end
  endtask

  task automatic wait_ready(input string name);
    for (int t = 0; t < 200 && !rdy; t++) @(negedge clk);
    chk({name, " ready"}, {15'd0, rdy}, 16'd1);
  endtask

  task automatic send(input string name, input int s, input logic [7:0] d,
                      input logic [1:0] m, input int n, input logic [15:0] bits);
    @(negedge clk);
    sel = s;
    #1;
    wait_ready(name);
    dv = 1'b1; tx_byte = d; mode = m;
    @(posedge clk);
    #1;
    dv = 1'b0; tx_byte = ~d; mode = ~m;   // later input changes must not matter
    check_frame(name, n, bits);
  endtask

  initial begin
    vecs[0] = '{"a5_8n1",  0, 8'hA5, 2'b00, 10, 16'b1101001010};
    vecs[1] = '{"80_8n1",  0, 8'h80, 2'b00, 10, 16'b1100000000};
    vecs[2] = '{"01_8n1",  0, 8'h01, 2'b11, 10, 16'b1000000010};
    vecs[3] = '{"13_7n1",  1, 8'h13, 2'b00,  9, 16'b100100110};
    vecs[4] = '{"00_8n2",  2, 8'h00, 2'b00, 11, 16'b11000000000};
`ifdef UART_TX_PARITY_EN
    vecs[5] = '{"13_7e1",  1, 8'h13, 2'b01, 10, 16'b1100100110};
    vecs[6] = '{"13_7o1",  1, 8'h13, 2'b10, 10, 16'b1000100110};
    vecs[7] = '{"ff_8e1",  0, 8'hFF, 2'b01, 11, 16'b10111111110};
`else
    vecs[5] = '{"13_7x1e", 1, 8'h13, 2'b01,  9, 16'b100100110};
    vecs[6] = '{"13_7x1o", 1, 8'h13, 2'b10,  9, 16'b100100110};
    vecs[7] = '{"ff_8x1",  0, 8'hFF, 2'b01, 10, 16'b1111111110};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst ser", {15'd0, ser_a}, 16'd1);
    chk("rst active", {15'd0, act_a}, 16'd0);
    chk("rst done", {15'd0, done_a}, 16'd0);
    chk("rst ready", {15'd0, rdy_a}, 16'd1);
    rst = 1'b0;

    // Table of single frames
    for (int v = 0; v < 8; v++)
      send(vecs[v].name, vecs[v].sel, vecs[v].data, vecs[v].mode, vecs[v].nbits, vecs[v].bits);

    // Held request: second frame accepted in the Done cycle, mid-frame DV ignored
    @(negedge clk);
    sel = 0;
    #1;
    wait_ready("b2b");
    done_seen = 0;
    dv = 1'b1; tx_byte = 8'h11; mode = 2'b00;
    @(posedge clk);
    #1;
    tx_byte = 8'h22;
    check_frame("b2b_11", 10, 16'b1000100010);
    @(posedge clk);
    #1;
    dv = 1'b0;
    check_frame("b2b_22", 10, 16'b1001000100);
    chk("b2b done count", 16'(done_seen), 16'd2);
    repeat (3) begin
      @(negedge clk);
      chk("b2b idle ser", {15'd0, ser}, 16'd1);
      chk("b2b idle active", {15'd0, act}, 16'd0);
    end

    // Reset during data bit 3 of 0x00 (line low), then a clean 0x5A frame
    dv = 1'b1; tx_byte = 8'h00;
    @(posedge clk);
    #1;
    dv = 1'b0;
    repeat (4 * C + 2) @(negedge clk);
    chk("mid active before rst", {15'd0, act}, 16'd1);
    chk("mid ser before rst", {15'd0, ser}, 16'd0);
    rst = 1'b1;
    #1;
    chk("mid rst ser", {15'd0, ser}, 16'd1);
    chk("mid rst active", {15'd0, act}, 16'd0);
    chk("mid rst ready", {15'd0, rdy}, 16'd1);
    chk("mid rst done", {15'd0, done}, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2 * C) begin
      @(negedge clk);
      chk("post rst done", {15'd0, done}, 16'd0);
      chk("post rst ser", {15'd0, ser}, 16'd1);
    end
    send("5a_after_rst", 0, 8'h5A, 2'b00, 10, 16'b1010110100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
